ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Upstream feeder for the tile configuration chain. Takes configuration words from the bitstream source over a valid/ready handshake and serializes them onto the chain's `ccff_head` input.
- Generates the per-cycle shift enable that gates `prog_clk` to the chain. Counts bits so the chain receives exactly CHAIN_LEN bits, then reports done.
- Sits between the bitstream interface and the `ccff_head` of the first tile; `ccff_tail` of the last tile returns here.

Parameters:
- CHAIN_LEN, 1024, total configuration bits in the chain (≥1).
- WORD_W, 8, width of the incoming configuration word (≥1).
- CNT_W, $clog2(CHAIN_LEN+1), bit counter width (derived, do not override).

Ports:
- prog_clk  in  1  configuration clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_start  in  1  pulse: begin a new load.
- cfg_abort  in  1  pulse: terminate the current load.
- cfg_data  in  WORD_W  configuration word; MSB is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts cfg_data this cycle.
- ccff_head  out  1  serial bit into the chain.
- ccff_shift_en  out  1  chain shift enable (external ICG on prog_clk).
- ccff_tail  in  1  serial bit out of the chain.
- busy  out  1  load in progress.
- done  out  1  sticky: CHAIN_LEN bits shifted.
- bit_cnt  out  CNT_W  bits shifted so far in this load.

Behaviour:
- Clock and reset: one clock, `prog_clk`. `reset` is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; shift register 0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE / DONE:
  - `cfg_start` → LOAD next cycle.
  - On that transition: `bit_cnt` clears to 0, `done` clears to 0, `busy` goes to 1.
- LOAD:
  - `cfg_ready`=1.
  - On `cfg_valid`&`cfg_ready`: word captured into the shift register; `wbits` = min(WORD_W, CHAIN_LEN−bit_cnt); → SHIFT.
- SHIFT:
  - `ccff_shift_en`=1 every cycle; `ccff_head` = current shift register MSB (registered).
  - The chain captures `ccff_head` at the rising edge ending that cycle.
  - Each cycle: `bit_cnt`+1, shift register shifts left, `wbits`−1.
- Back-to-back handoff:
  - `cfg_ready` is also 1 in the last SHIFT cycle of a word when `bit_cnt`+1 < CHAIN_LEN.
  - A handshake in that cycle loads the next word and stays in SHIFT, so a continuous stream produces no bubble.
  - Without a handshake: → LOAD, with `ccff_shift_en`=0 while starved.
- End of load:
  - When `bit_cnt` reaches CHAIN_LEN: → DONE; `done`=1, `busy`=0, `ccff_shift_en`=0 the same cycle `bit_cnt` shows CHAIN_LEN.
  - `cfg_ready`=0 in the final shift cycle.
  - Unused low bits of the final partial word are discarded.
- `ccff_shift_en` is never high outside SHIFT. Exactly CHAIN_LEN enable cycles occur per completed load.
- `cfg_start` in LOAD/SHIFT is ignored.
- `cfg_abort`:
  - In LOAD/SHIFT: → IDLE next cycle; `ccff_shift_en`, `cfg_ready`, `busy` drop at that edge; `bit_cnt` holds; `done` stays 0.
  - Elsewhere: ignored.
- Priority: `cfg_abort` over handshake; `cfg_start`+`cfg_abort` together in IDLE → stay IDLE.
- Reset mid-load: immediate return to reset values; chain contents undefined, software reloads.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- Defined:
  - Adds outputs `rb_data` [WORD_W], `rb_valid`.
  - During each SHIFT cycle, `ccff_tail` is sampled into a readback register, MSB first. These are the previous chain contents.
  - `rb_valid` pulses 1 cycle after every WORD_W sampled bits, and after the final partial word, which is left-aligned and zero-padded.
  - No backpressure on readback.
- Undefined: ports absent, `ccff_tail` unused.

Test Plan:
- Stream and partial word: CHAIN_LEN=20, WORD_W=8, words 0xA5,0x3C,0xF0 presented continuously.
  - `ccff_shift_en` high exactly 20 consecutive cycles.
  - `ccff_head` sequence 10100101 00111100 1111.
  - `done`=1, `bit_cnt`=20, `busy`=0.
- Starvation: `cfg_valid` dropped 3 cycles between words.
  - `ccff_shift_en` low those 3 cycles.
  - Total enable count still 20; bit order unchanged.
- Abort: `cfg_abort` after 10 shift cycles.
  - Next cycle state IDLE, `ccff_shift_en`=0, `busy`=0, `done`=0, `bit_cnt`=10.
  - Subsequent `cfg_start` clears `bit_cnt` to 0 and completes a full 20-bit load.
- Reset mid-load: async `reset` pulse between clock edges.
  - All outputs 0 immediately.
  - `cfg_start` is ignored until `reset` deasserts.
- Readback (CCFF_READBACK_EN): chain model preloaded with 0x5A,0xC3,0x9 (20 bits), then full load.
  - `rb_data` sequence 0x5A, 0xC3, 0x90 with three `rb_valid` pulses.
- Back-to-back start: `cfg_start` asserted in DONE.
  - Load restarts: `done`→0, `bit_cnt`→0; `cfg_start` during SHIFT has no effect.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: takes configuration words over a valid/ready handshake
// and serializes them MSB-first onto the configuration chain head. It also
// drives the chain shift enable and counts bits, so the chain receives exactly
// CHAIN_LEN bits.
// Optional build macro CCFF_READBACK_EN: while shifting, the loader samples
// ccff_tail and returns the previous chain contents as words on rb_data/rb_valid.
module ccff_chain_loader #(
  parameter  int CHAIN_LEN = 1024,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] sr, sr_n;
  logic [WB_W-1:0]   wbits, wbits_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W:0]    cnt_n_p1;
  logic              done_n, ready_n, hs, start_go, fin;

  // A new word may supply fewer bits than WORD_W when it is the tail of the chain.
  function automatic logic [WB_W-1:0] word_bits(input logic [CNT_W-1:0] c);
    int rem;
    rem = CHAIN_LEN - int'(c);
    return (rem > WORD_W) ? WB_W'(WORD_W) : WB_W'(rem);
  endfunction

  assign hs        = cfg_valid & cfg_ready;
  assign ccff_head = sr[WORD_W-1];
  assign cnt_n_p1  = {1'b0, cnt_n} + 1'b1;

  // Next-state logic: abort beats handshake, start+abort in IDLE stays IDLE.
  always_comb begin
    state_n  = state;
    sr_n     = sr;
    wbits_n  = wbits;
    cnt_n    = bit_cnt;
    done_n   = done;
    start_go = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (cfg_start && !(state == IDLE && cfg_abort)) begin
          state_n  = LOAD;
          cnt_n    = '0;
          done_n   = 1'b0;
          start_go = 1'b1;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          state_n = IDLE;
        end else if (hs) begin
          state_n = SHIFT;
          sr_n    = cfg_data;
          wbits_n = word_bits(bit_cnt);
        end
      end
      SHIFT: begin
        if (cfg_abort) begin
          state_n = IDLE;
        end else begin
          cnt_n   = bit_cnt + 1'b1;
          sr_n    = sr << 1;
          wbits_n = wbits - 1'b1;
          if (cnt_n == CNT_W'(CHAIN_LEN)) begin
            state_n = DONE;
            done_n  = 1'b1;
            fin     = 1'b1;
          end else if (wbits == WB_W'(1)) begin
            // Last bit of this word: chain straight into the next word if offered.
            if (hs) begin
              sr_n    = cfg_data;
              wbits_n = word_bits(cnt_n);
            end else begin
              state_n = LOAD;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Ready is registered: high in LOAD, and in the last shift cycle of a word
  // when more bits remain, so a continuous stream has no bubble.
  assign ready_n = (state_n == LOAD) ||
                   (state_n == SHIFT && wbits_n == WB_W'(1) &&
                    cnt_n_p1 < (CNT_W+1)'(CHAIN_LEN));

  // Loader FSM with registered outputs.
  always_ff @(posedge prog_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sr            <= '0;
      wbits         <= '0;
      bit_cnt       <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      cfg_ready     <= 1'b0;
      ccff_shift_en <= 1'b0;
    end else begin
      state         <= state_n;
      sr            <= sr_n;
      wbits         <= wbits_n;
      bit_cnt       <= cnt_n;
      done          <= done_n;
      busy          <= (state_n == LOAD) || (state_n == SHIFT);
      cfg_ready     <= ready_n;
      ccff_shift_en <= (state_n == SHIFT);
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_sr, rb_shift;
  logic [WB_W-1:0]   rb_cnt, rb_cnt_p1;
  logic              rb_sample;

  assign rb_shift  = WORD_W'({rb_sr, ccff_tail});
  assign rb_cnt_p1 = rb_cnt + 1'b1;
  assign rb_sample = (state == SHIFT) && !cfg_abort;

  // Collect tail bits MSB first; emit full words and a left-aligned final partial word.
  always_ff @(posedge prog_clk or posedge reset) begin
    if (reset) begin
      rb_sr    <= '0;
      rb_cnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (start_go) begin
        rb_cnt <= '0;
      end else if (rb_sample) begin
        rb_sr <= rb_shift;
        if (rb_cnt_p1 == WB_W'(WORD_W) || fin) begin
          rb_data  <= rb_shift << (WB_W'(WORD_W) - rb_cnt_p1);
          rb_valid <= 1'b1;
          rb_cnt   <= '0;
        end else begin
          rb_cnt <= rb_cnt_p1;
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with CHAIN_LEN=20, WORD_W=8 and a
// behavioural 20-bit chain hanging off ccff_head/ccff_tail.
module tb_ccff_chain_loader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int CW = $clog2(CL + 1);

  logic          prog_clk = 1'b0;
  logic          reset, cfg_start, cfg_abort, cfg_valid;
  logic [WW-1:0] cfg_data;
  logic          cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done;
  logic [CW-1:0] bit_cnt;
`ifdef CCFF_READBACK_EN
  logic [WW-1:0] rb_data;
  logic          rb_valid;
  int            rb_n = 0;
  logic [23:0]   rb_log = '0;
`endif

  int vectors = 0, miscompares = 0;
  int en_tot = 0, idle_tot = 0, viol = 0;
  int e0, i0, rb0;
  logic [31:0]   hist = '0;
  logic [CL-1:0] chain = 20'h5AC39;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk(prog_clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .bit_cnt(bit_cnt)
`ifdef CCFF_READBACK_EN
    , .rb_data(rb_data), .rb_valid(rb_valid)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: shifts head in at the edge ending each enabled cycle.
  assign ccff_tail = chain[CL-1];
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};

  // Observe outputs mid-cycle: enable count, head history, starved cycles.
  always @(negedge prog_clk) begin
    if (ccff_shift_en) begin
      en_tot <= en_tot + 1;
      hist   <= {hist[30:0], ccff_head};
    end
    if (busy && !ccff_shift_en) idle_tot <= idle_tot + 1;
    if (ccff_shift_en && !busy) viol <= viol + 1;
`ifdef CCFF_READBACK_EN
    if (rb_valid) begin
      rb_n   <= rb_n + 1;
      rb_log <= {rb_log[15:0], rb_data};
    end
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic send(input logic [WW-1:0] w);
    int n = 0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 100) begin step(); n++; end
    chk("send_timeout", 32'(n < 100), 1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_ready && n < 100) begin step(); n++; end
    chk("ready_timeout", 32'(n < 100), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin step(); n++; end
    chk("done_timeout", 32'(n < 100), 1);
  endtask

  task automatic start();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic full_load(input string tag);
    send(8'hA5); send(8'h3C); send(8'hF0);
    wait_done();
    chk({tag, "_cnt"}, 32'(bit_cnt), 20);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_chain"}, 32'(chain), 32'hA53CF);
  endtask

  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    #2;
    chk("rst_ready", 32'(cfg_ready), 0);
    chk("rst_head",  32'(ccff_head), 0);
    chk("rst_en",    32'(ccff_shift_en), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_cnt",   32'(bit_cnt), 0);
    step();
    reset = 1'b0;
    step();

    // Continuous stream with a partial final word.
    start();
    chk("load_busy",  32'(busy), 1);
    chk("load_ready", 32'(cfg_ready), 1);
    e0 = en_tot; i0 = idle_tot;
`ifdef CCFF_READBACK_EN
    rb0 = rb_n;
`endif
    send(8'hA5); send(8'h3C); send(8'hF0);
    wait_done();
    chk("strm_cnt",   32'(bit_cnt), 20);
    chk("strm_done",  32'(done), 1);
    chk("strm_busy",  32'(busy), 0);
    chk("strm_en",    32'(ccff_shift_en), 0);
    chk("strm_ready", 32'(cfg_ready), 0);
    chk("strm_encnt", 32'(en_tot - e0), 20);
    chk("strm_idle",  32'(idle_tot - i0), 1);
    chk("strm_head",  hist & 32'hFFFFF, 32'hA53CF);
    chk("strm_chain", 32'(chain), 32'hA53CF);
`ifdef CCFF_READBACK_EN
    chk("rb_pulses", 32'(rb_n - rb0), 3);
    chk("rb_words",  32'(rb_log), 32'h5AC390);
`endif

    // Start from DONE restarts; then starve between words.
    start();
    chk("b2b_done", 32'(done), 0);
    chk("b2b_cnt",  32'(bit_cnt), 0);
    chk("b2b_busy", 32'(busy), 1);
    e0 = en_tot; i0 = idle_tot;
`ifdef CCFF_READBACK_EN
    rb0 = rb_n;
`endif
    send(8'hA5);
    wait_ready();
    step();
    chk("starve_en", 32'(ccff_shift_en), 0);
    step(); step();
    send(8'h3C);
    wait_ready();
    repeat (3) step();
    send(8'hF0);
    wait_done();
    chk("stv_cnt",   32'(bit_cnt), 20);
    chk("stv_encnt", 32'(en_tot - e0), 20);
    chk("stv_idle",  32'(idle_tot - i0), 7);
    chk("stv_head",  hist & 32'hFFFFF, 32'hA53CF);
    chk("stv_chain", 32'(chain), 32'hA53CF);
`ifdef CCFF_READBACK_EN
    chk("rb2_pulses", 32'(rb_n - rb0), 3);
    chk("rb2_words",  32'(rb_log), 32'hA53CF0);
`endif

    // Start during SHIFT is ignored; abort after 10 shift cycles.
    start();
    send(8'hA5);
    cfg_data = 8'h3C; cfg_valid = 1'b1;
    repeat (3) step();
    start();
    chk("shift_start_cnt", 32'(bit_cnt), 4);
    chk("shift_start_en",  32'(ccff_shift_en), 1);
    repeat (4) step();
    cfg_valid = 1'b0;
    chk("handoff_en",  32'(ccff_shift_en), 1);
    chk("handoff_cnt", 32'(bit_cnt), 8);
    step(); step();
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    chk("abort_cnt",   32'(bit_cnt), 10);
    chk("abort_en",    32'(ccff_shift_en), 0);
    chk("abort_busy",  32'(busy), 0);
    chk("abort_done",  32'(done), 0);
    chk("abort_ready", 32'(cfg_ready), 0);
    cfg_start = 1'b1; cfg_abort = 1'b1;
    step();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_cnt",  32'(bit_cnt), 10);
    start();
    chk("restart_cnt", 32'(bit_cnt), 0);
    e0 = en_tot;
    full_load("reload");
    chk("reload_encnt", 32'(en_tot - e0), 20);

    // Asynchronous reset between edges in the middle of a load.
    start();
    send(8'hA5);
    step(); step();
    #3;
    reset = 1'b1; cfg_start = 1'b1;
    #1;
    chk("arst_en",    32'(ccff_shift_en), 0);
    chk("arst_busy",  32'(busy), 0);
    chk("arst_cnt",   32'(bit_cnt), 0);
    chk("arst_ready", 32'(cfg_ready), 0);
    chk("arst_head",  32'(ccff_head), 0);
    chk("arst_done",  32'(done), 0);
    step(); step();
    chk("arst_start_ignored", 32'(busy), 0);
    #3;
    reset = 1'b0;
    step();
    cfg_start = 1'b0;
    chk("post_rst_busy", 32'(busy), 1);
    full_load("post_rst");

    chk("en_outside_busy", 32'(viol), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
